// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel pipeline blocks.
package sobel_pkg;

    localparam int unsigned PIX_W_DEF = 8;

    // Window tap indices, row-major: top-left .. bottom-right.
    localparam int unsigned TAP_TL   = 0;
    localparam int unsigned TAP_TC   = 1;
    localparam int unsigned TAP_TR   = 2;
    localparam int unsigned TAP_ML   = 3;
    localparam int unsigned TAP_MC   = 4;
    localparam int unsigned TAP_MR   = 5;
    localparam int unsigned TAP_BL   = 6;
    localparam int unsigned TAP_BC   = 7;
    localparam int unsigned TAP_BR   = 8;
    localparam int unsigned NUM_TAPS = 9;

    // Bits needed to count 0..n-1; never less than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixels, addressed by column. The read is combinational so the
// value being displaced is available in the same cycle that overwrites it.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned DEPTH = 6,
    localparam int unsigned AW   = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    // Contents are never reset; row gating upstream keeps stale data out of windows.
    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Write the new pixel over the old one at this column.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_window_buffer.sv
// 3x3 neighbourhood generator: tracks raster position, keeps two previous rows in
// line buffers and emits a window only when all nine taps are inside the frame.
module sobel_window_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6,
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] grayscale_i,
    input  logic             done_i,
    output logic [PIX_W-1:0] d0_o,
    output logic [PIX_W-1:0] d1_o,
    output logic [PIX_W-1:0] d2_o,
    output logic [PIX_W-1:0] d3_o,
    output logic [PIX_W-1:0] d4_o,
    output logic [PIX_W-1:0] d5_o,
    output logic [PIX_W-1:0] d6_o,
    output logic [PIX_W-1:0] d7_o,
    output logic [PIX_W-1:0] d8_o,
    output logic             done_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             frame_done_o
);

    localparam int unsigned COL_W = cnt_width(IMG_W);
    localparam int unsigned ROW_W = cnt_width(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] win_q [NUM_TAPS];
    logic [PIX_W-1:0] win_d [NUM_TAPS];
    logic             done_q, done_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             frame_done_q, frame_done_d;

    logic             accept;
    logic [PIX_W-1:0] r1_pix;
    logic [PIX_W-1:0] r2_pix;

    // Reset wins over a same-edge pixel.
    assign accept = done_i & rst;

    // Row r-1: takes the incoming pixel.
    sobel_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_line_r1 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (grayscale_i),
        .rdata_o (r1_pix)
    );

    // Row r-2: takes the value displaced from row r-1.
    sobel_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_line_r2 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (r1_pix),
        .rdata_o (r2_pix)
    );

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (done_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shift and flags; the accepted pixel lands in the bottom-right tap.
    always_comb begin
        win_d        = win_q;
        done_d       = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_done_d = 1'b0;
        if (done_i) begin
            win_d[TAP_TL] = win_q[TAP_TC];
            win_d[TAP_TC] = win_q[TAP_TR];
            win_d[TAP_TR] = r2_pix;
            win_d[TAP_ML] = win_q[TAP_MC];
            win_d[TAP_MC] = win_q[TAP_MR];
            win_d[TAP_MR] = r1_pix;
            win_d[TAP_BL] = win_q[TAP_BC];
            win_d[TAP_BC] = win_q[TAP_BR];
            win_d[TAP_BR] = grayscale_i;

            done_d       = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
            sof_d        = (row_q == ROW_TWO) && (col_q == COL_TWO);
            eof_d        = (row_q == ROW_LAST) && (col_q == COL_LAST);
            frame_done_d = eof_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            done_q       <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            done_q       <= done_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    assign d0_o         = win_q[TAP_TL];
    assign d1_o         = win_q[TAP_TC];
    assign d2_o         = win_q[TAP_TR];
    assign d3_o         = win_q[TAP_ML];
    assign d4_o         = win_q[TAP_MC];
    assign d5_o         = win_q[TAP_MR];
    assign d6_o         = win_q[TAP_BL];
    assign d7_o         = win_q[TAP_BC];
    assign d8_o         = win_q[TAP_BR];
    assign done_o       = done_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer with a 6x6 frame and 8-bit pixels.
module tb_sobel_window_buffer;

    localparam int W = 6;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] grayscale_i = '0;
    logic       done_i = 1'b0;
    logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic       done_o, sof_o, eof_o, frame_done_o;
    logic [7:0] dout [9];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sobel_window_buffer #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .grayscale_i  (grayscale_i),
        .done_i       (done_i),
        .d0_o         (d0_o),
        .d1_o         (d1_o),
        .d2_o         (d2_o),
        .d3_o         (d3_o),
        .d4_o         (d4_o),
        .d5_o         (d5_o),
        .d6_o         (d6_o),
        .d7_o         (d7_o),
        .d8_o         (d8_o),
        .done_o       (done_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .frame_done_o (frame_done_o)
    );

    assign dout[0] = d0_o;
    assign dout[1] = d1_o;
    assign dout[2] = d2_o;
    assign dout[3] = d3_o;
    assign dout[4] = d4_o;
    assign dout[5] = d5_o;
    assign dout[6] = d6_o;
    assign dout[7] = d7_o;
    assign dout[8] = d8_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Present one pixel for one edge, then sample the registered result.
    task automatic push(input int v);
        grayscale_i = 8'(v);
        done_i      = 1'b1;
        @(posedge clk);
        #1;
        done_i      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s_d%0d", tag, k), 32'(dout[k]), 32'd0);
        end
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_sof"}, 32'(sof_o), 32'd0);
        check({tag, "_eof"}, 32'(eof_o), 32'd0);
        check({tag, "_fdone"}, 32'(frame_done_o), 32'd0);
    endtask

    // Pixels base+1..base+36; optional 3-cycle gap after the 14th pixel.
    task automatic run_frame(input string name, input int base, input bit gap);
        int wins;
        int r, c, exp_v;
        wins = 0;
        for (int p = 1; p <= W * H; p++) begin
            push(base + p);
            r = (p - 1) / W;
            c = (p - 1) % W;
            exp_v = (r >= 2 && c >= 2) ? 1 : 0;
            check($sformatf("%s_done_p%0d", name, p), 32'(done_o), 32'(exp_v));
            check($sformatf("%s_sof_p%0d", name, p), 32'(sof_o), 32'(p == 15));
            check($sformatf("%s_eof_p%0d", name, p), 32'(eof_o), 32'(p == 36));
            check($sformatf("%s_fdone_p%0d", name, p), 32'(frame_done_o), 32'(p == 36));
            if (done_o) wins++;
            if (exp_v == 1) begin
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("%s_p%0d_d%0d", name, p, k), 32'(dout[k]),
                          32'(base + p - (2 - k / 3) * W - (2 - k % 3)));
                end
            end
            if (p == 15) begin
                check({name, "_first_d0"}, 32'(d0_o), 32'(base + 1));
                check({name, "_first_d4"}, 32'(d4_o), 32'(base + 8));
                check({name, "_first_d8"}, 32'(d8_o), 32'(base + 15));
            end
            if (p == 21) begin
                check({name, "_wrap_d0"}, 32'(d0_o), 32'(base + 7));
                check({name, "_wrap_d4"}, 32'(d4_o), 32'(base + 14));
                check({name, "_wrap_d8"}, 32'(d8_o), 32'(base + 21));
            end
            if (p == 36) begin
                check({name, "_last_d0"}, 32'(d0_o), 32'(base + 22));
                check({name, "_last_d4"}, 32'(d4_o), 32'(base + 29));
                check({name, "_last_d8"}, 32'(d8_o), 32'(base + 36));
            end
            if (gap && p == 14) begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check({name, "_gap_done"}, 32'(done_o), 32'd0);
                    check({name, "_gap_sof"}, 32'(sof_o), 32'd0);
                    check({name, "_gap_fdone"}, 32'(frame_done_o), 32'd0);
                    check({name, "_gap_d8"}, 32'(d8_o), 32'(base + 14));
                end
            end
        end
        check({name, "_windows"}, 32'(wins), 32'd16);
    endtask

    initial begin
        rst    = 1'b0;
        done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        run_frame("basic", 0, 1'b0);
        run_frame("gap", 0, 1'b1);

        // Two frames with no idle cycle between them.
        run_frame("b2b_a", 0, 1'b0);
        run_frame("b2b_b", 36, 1'b0);

        // Abort partway through; the pixel offered with reset must be dropped.
        for (int p = 1; p <= 20; p++) push(p);
        grayscale_i = 8'd99;
        done_i      = 1'b1;
        rst         = 1'b0;
        @(posedge clk);
        #1;
        done_i = 1'b0;
        rst    = 1'b1;
        check_all_zero("midrst");
        run_frame("after_rst", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Parametrised 3x3 neighbourhood generator for the Sobel pipeline, sitting between the grayscale converter and the gradient kernel. It accepts a raster-order pixel stream of configurable width and frame size, and holds the two previous image rows in line buffers. It emits a 3x3 window only when every tap lies inside the frame and within the same three rows, so windows never wrap across a line edge. It also flags the first and last window of each frame and runs back-to-back frames without re-reset.

## Interface
- IMG_W, 6: pixels per line (≥3)
- IMG_H, 6: lines per frame (≥3)
- PIX_W, 8: bits per pixel
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- grayscale_i  in  PIX_W  input pixel, raster order
- done_i  in  1  input-valid strobe; pixel accepted on any edge with done_i=1
- d0_o..d8_o  out  PIX_W each  window taps, row-major: d0 top-left, d4 centre, d8 bottom-right
- done_o  out  1  window-valid, one-cycle pulse per window
- sof_o  out  1  high with the first window of a frame
- eof_o  out  1  high with the last window of a frame
- frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- col (0..IMG_W-1) and row (0..IMG_H-1) counters advance only on accepted pixels. col wraps to 0 and increments row. The row counter wraps to 0 after the last pixel of the frame.
- Two line buffers of depth IMG_W hold rows r-1 and r-2. Each accepted pixel is written to the r-1 buffer. The displaced r-1 value moves to the r-2 buffer.
- A 3x3 shift register takes {r-2, r-1, current} column values on each accepted pixel.
- Window condition: row≥2 and col≥2 for the accepted pixel, which becomes d8. The window centre is (row-1, col-1).
- The block emits (IMG_W-2)*(IMG_H-2) windows per frame.
- sof_o is asserted at row=2, col=2. eof_o is asserted at row=IMG_H-1, col=IMG_W-1.
- frame_done_o fires on acceptance of pixel (IMG_H-1, IMG_W-1), whether or not a window is emitted. It coincides with eof_o.
- Gaps (done_i=0) freeze all state. During a gap done_o, sof_o, eof_o and frame_done_o are 0 and d*_o hold their last value.
- Line-buffer contents are not cleared at frame boundaries. Row gating ensures stale data never reaches a valid window.
- No backpressure: the downstream block must accept one window per cycle.

## Timing
- Reset (rst=0 at an edge):
  - col and row go to 0.
  - done_o, sof_o, eof_o and frame_done_o go to 0.
  - d0_o..d8_o go to 0.
  - Line-buffer RAM is not cleared.
- Latency: window outputs and flags are registered. They are valid on the edge after the accepting edge of the completing pixel (1 cycle).
- Continuous done_i gives a throughput of 1 pixel per cycle.
- Reset mid-frame aborts the current frame. The next accepted pixel is (0,0), and no window is emitted until row 2 of the new frame.
- Reset has priority over done_i on the same edge.
- Frame wrap with done_i held high: the pixel after (IMG_H-1, IMG_W-1) is (0,0) of the next frame, with no idle cycle required.

## Structure
- Shared package sobel_pkg holds:
  - the default PIX_W;
  - the tap index constants (TAP_TL..TAP_BR = 0..8);
  - a clog2-based counter-width function reused by the kernel.
- One sub-module, sobel_line_buffer. It is a parametrised PIX_W × IMG_W circular buffer with a single read-before-write address (col), instantiated twice.
- Counters, window shift register and flag logic stay in the top module.

## Test plan
- **Basic window:** IMG_W=IMG_H=6, pixels 1..36 continuous. First done_o follows pixel 15 with d0..d8 = 1,2,3,7,8,9,13,14,15 and sof_o=1. The frame produces 16 done_o pulses in total.
- **Line wrap:**
  - Pixels 17 and 18 emit windows.
  - Pixels 19 and 20 emit none.
  - Pixel 21 emits d0=7, d4=14, d8=21.
- **Frame end:** pixel 36 gives d0=22, d4=29, d8=36, with eof_o=1 and frame_done_o=1 together.
- **Gaps:** insert done_i=0 for 3 cycles between pixels 14 and 15. The window values are identical to the basic case, and done_o stays low during the gap.
- **Back-to-back frames:** send 72 continuous pixels with values 1..72. The second frame's first window is d0=37 and d8=51, with sof_o=1. No stale row-1/row-2 data appears.
- **Reset mid-frame:** pulse rst=0 after pixel 20, then send 1..36. All outputs read 0 after reset, and the frame result matches the basic case exactly.
